// File: rtl/alu_cmd_issue_pkg.sv
// Shared opcode, width and FSM state definitions
// for the ALU command issue stage.
package alu_pkg;

  localparam int OPW_DEF = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_SUB = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WAIT = 2'b10
  } state_e;

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Command, ALU and result bundle between the issue
// stage (slave) and its environment (master).
interface alu_cmd_issue_if
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_code;
  logic [OPW-1:0] cmd_a;
  logic [OPW-1:0] cmd_b;
  logic [1:0]     alu_code;
  logic [OPW-1:0] alu_a;
  logic [OPW-1:0] alu_b;
  logic [OPW:0]   alu_c;
  logic           res_valid;
  logic           res_ready;
  logic [OPW:0]   res_data;
  logic [1:0]     res_code;
  logic [CW-1:0]  count;

  modport slave (
    input  cmd_valid, cmd_code, cmd_a, cmd_b,
    input  alu_c, res_ready,
    output cmd_ready, alu_code, alu_a, alu_b,
    output res_valid, res_data, res_code, count
  );

  modport master (
    output cmd_valid, cmd_code, cmd_a, cmd_b,
    output alu_c, res_ready,
    input  cmd_ready, alu_code, alu_a, alu_b,
    input  res_valid, res_data, res_code, count
  );

endinterface

// File: rtl/alu_cmd_issue_fifo.sv
// Synchronous command FIFO; occupancy counter
// decides full/empty so pointers may simply wrap.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 + 2 * OPW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && (r_cnt < FULL);
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= i_data;
      r_wr        <= r_wr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
    end else if (w_pop) begin
      r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_pop && !w_push) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// Issues queued commands to an external ALU on
// registered inputs and captures its settled result.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OPW   = OPW_DEF
) (
  input logic            clk,
  input logic            rst_n,
  alu_cmd_issue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 2 + 2 * OPW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e         r_state;
  state_e         w_state_nx;
  logic           w_push;
  logic           w_pop;
  logic           w_empty;
  logic [DW-1:0]  w_push_data;
  logic [DW-1:0]  w_head;
  logic [CW-1:0]  w_count;
  logic [1:0]     r_alu_code;
  logic [OPW-1:0] r_alu_a;
  logic [OPW-1:0] r_alu_b;
  logic [OPW:0]   r_res_data;
  logic [1:0]     r_res_code;
  logic           w_msb;

  assign w_empty     = (w_count == '0);
  assign w_push      = bus.cmd_valid && bus.cmd_ready;
  assign w_push_data = {bus.cmd_code, bus.cmd_a, bus.cmd_b};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.res_ready) begin
          w_pop      = !w_empty;
          w_state_nx = w_empty ? S_IDLE : S_EXEC;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_code <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
    end else if (w_pop) begin
      r_alu_code <= w_head[DW-1 -: 2];
      r_alu_a    <= w_head[2*OPW-1 -: OPW];
      r_alu_b    <= w_head[OPW-1:0];
    end
  end

  // the ALU leaves its carry bit stale for AND
  assign w_msb = bus.alu_c[OPW] && (r_alu_code != OP_AND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_code <= '0;
    end else if (r_state == S_EXEC) begin
      r_res_data <= {w_msb, bus.alu_c[OPW-1:0]};
      r_res_code <= r_alu_code;
    end
  end

  assign bus.cmd_ready = (w_count < FULL);
  assign bus.alu_code  = r_alu_code;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.res_valid = (r_state == S_WAIT);
  assign bus.res_data  = r_res_data;
  assign bus.res_code  = r_res_code;
  assign bus.count     = w_count;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Randomised bench for alu_cmd_issue with a queue
// based result model and an external ALU stand-in.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int OPW   = 4;

  typedef struct {
    logic [1:0] code;
    logic [4:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   hold = 1'b0;
  bit   stream = 1'b0;
  int   n_stream = 0;
  int   last_cyc = 0;
  logic [4:0] d;

  always #5 clk = ~clk;

  alu_cmd_issue_if #(.DEPTH(DEPTH), .OPW(OPW)) bus ();

  alu_cmd_issue #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ALU stand-in: bit 4 left stale-high on AND
  always_comb begin
    case (bus.alu_code)
      2'b00:   bus.alu_c = {1'b1, bus.alu_a & bus.alu_b};
      2'b01:   bus.alu_c = {1'b0, bus.alu_a | bus.alu_b};
      2'b10:   bus.alu_c = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      default: bus.alu_c = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_res(input logic [1:0] c,
                                         input int a,
                                         input int b);
    case (c)
      2'd0:    return 5'(a & b);
      2'd1:    return 5'(a | b);
      2'd2:    return 5'((a - b + 32) % 32);
      default: return 5'((a + b) % 32);
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n || !mon_en) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_valid", 32'(bus.res_valid), 1);
      if (bus.res_valid && q.size() != 0) begin
        chk("res_data", 32'(bus.res_data), 32'(q[0].res));
        chk("res_code", 32'(bus.res_code), 32'(q[0].code));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) begin
          chk("spurious_res", 1, 0);
        end else begin
          e = q.pop_front();
        end
        if (stream) begin
          if (n_stream > 0) chk("stream_gap", cyc - last_cyc, 2);
          n_stream++;
          last_cyc = cyc;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        q.push_back('{code: bus.cmd_code,
                      res: ref_res(bus.cmd_code,
                                   int'(bus.cmd_a),
                                   int'(bus.cmd_b))});
      end
      hold = bus.res_valid && !bus.res_ready;
    end
  end

  task automatic push(input logic [1:0] c,
                      input logic [3:0] a,
                      input logic [3:0] b);
    bit ok = 1'b0;
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = c;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic push_rand();
    push(2'($urandom_range(0, 3)),
         4'($urandom_range(0, 15)),
         4'($urandom_range(0, 15)));
  endtask

  task automatic wait_valid(output logic [4:0] data);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 50);
    if (!bus.res_valid) chk("valid_timeout", 0, 1);
    data = bus.res_data;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || bus.res_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n < 200), 1);
    chk({tag, "_count"}, 32'(bus.count), 0);
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    chk({t, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({t, "_res_data"}, 32'(bus.res_data), 0);
    chk({t, "_res_code"}, 32'(bus.res_code), 0);
    chk({t, "_alu_code"}, 32'(bus.alu_code), 0);
    chk({t, "_alu_a"}, 32'(bus.alu_a), 0);
    chk({t, "_alu_b"}, 32'(bus.alu_b), 0);
    chk({t, "_count"}, 32'(bus.count), 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #20;
    chk_rst("rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single ADD, latency check
    bus.res_ready = 1'b1;
    push(2'b11, 4'd9, 4'd8);
    chk("t1_count_push", 32'(bus.count), 1);
    @(posedge clk);
    #1;
    chk("t1_alu_code", 32'(bus.alu_code), 3);
    chk("t1_alu_a", 32'(bus.alu_a), 9);
    chk("t1_alu_b", 32'(bus.alu_b), 8);
    chk("t1_count_pop", 32'(bus.count), 0);
    chk("t1_early_valid", 32'(bus.res_valid), 0);
    @(posedge clk);
    #1;
    chk("t1_valid", 32'(bus.res_valid), 1);
    chk("t1_data", 32'(bus.res_data), 17);
    chk("t1_code", 32'(bus.res_code), 3);
    @(posedge clk);
    #1;
    chk("t1_idle_valid", 32'(bus.res_valid), 0);
    chk("t1_idle_count", 32'(bus.count), 0);

    // SUB wrap then AND with stale carry
    push(2'b10, 4'd3, 4'd5);
    push(2'b00, 4'hF, 4'hA);
    wait_valid(d);
    chk("t2_sub", 32'(d), 32'h1E);
    @(posedge clk);
    #1;
    wait_valid(d);
    chk("t2_and", 32'(d), 32'h0A);
    @(posedge clk);
    #1;

    // backpressure
    bus.res_ready = 1'b0;
    repeat (5) push_rand();
    chk("t3_count_full", 32'(bus.count), 4);
    chk("t3_ready_full", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'($urandom_range(0, 3));
    bus.cmd_a     = 4'($urandom_range(0, 15));
    bus.cmd_b     = 4'($urandom_range(0, 15));
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("t3_count_extra", 32'(bus.count), 4);
    chk("t3_ready_extra", 32'(bus.cmd_ready), 0);
    chk("t3_valid_held", 32'(bus.res_valid), 1);
    bus.res_ready = 1'b1;
    drain("t3_drain");

    // streaming with res_ready held high
    stream   = 1'b1;
    n_stream = 0;
    repeat (8) push_rand();
    drain("t4_drain");
    stream = 1'b0;
    chk("t4_results", n_stream, 8);

    // random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          push_rand();
        end
      end
      begin
        repeat (250) begin
          @(posedge clk);
          #1;
          bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.res_ready = 1'b1;
    drain("t6_drain");

    // async reset while in EXEC with 3 queued
    bus.res_ready = 1'b0;
    repeat (5) push_rand();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("t5_count_exec", 32'(bus.count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("t5_async");
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_post_valid", 32'(bus.res_valid), 0);
    chk("t5_post_count", 32'(bus.count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Command issue and result capture stage that sits directly upstream of the 4-bit combinational ALU (`code`, `a`, `b` in, 5-bit `c` out). It buffers opcode/operand commands from a valid/ready producer in a small FIFO. It presents one command at a time to the ALU on registered outputs, samples the ALU result after a full settle cycle, and hands the result downstream on a valid/ready interface.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `OPW`, default 4: operand width; the result is `OPW+1` bits.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  producer presents a command.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_code`  in  2  opcode: 00 AND, 01 OR, 10 SUB (a−b), 11 ADD.
- `cmd_a`  in  OPW  operand a.
- `cmd_b`  in  OPW  operand b.
- `alu_code`  out  2  registered opcode to the ALU `code` input.
- `alu_a`  out  OPW  registered operand to the ALU `a` input.
- `alu_b`  out  OPW  registered operand to the ALU `b` input.
- `alu_c`  in  OPW+1  combinational result from the ALU `c` output.
- `res_valid`  out  1  result held for the consumer.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  OPW+1  captured result.
- `res_code`  out  2  opcode that produced `res_data`.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** a command is pushed when `cmd_valid && cmd_ready`.
- **`cmd_ready`:** equals `count < DEPTH`. It depends only on registered count, not on a same-cycle pop.
- **FSM states:** IDLE, EXEC, WAIT.
- **IDLE:** if `count != 0`, pop the head, load `alu_code`/`alu_a`/`alu_b`, and go to EXEC. Otherwise stay in IDLE.
- **EXEC:** the ALU inputs are held stable for the whole cycle. At the end of the cycle, capture `alu_c` into `res_data` and `alu_code` into `res_code`, then go to WAIT.
- **AND result:** when `alu_code == 00`, `res_data[OPW]` is forced to 0. The downstream ALU leaves `c[4]` stale for AND.
- **WAIT:** `res_valid = 1`.
  - On `res_ready` with `count != 0`: pop the next command, load the `alu_*` registers, go to EXEC.
  - On `res_ready` with `count == 0`: go to IDLE.
  - Without `res_ready`: hold all outputs unchanged.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Push while full:** cannot occur, since `cmd_ready = 0`. A `cmd_valid` while full is ignored, with no overwrite.
- **Pointer wrap:** pointers wrap modulo `DEPTH`. Full/empty is derived from `count`, not from pointer equality.
- **Arithmetic:** none in this block. SUB and ADD wrap modulo 2^(OPW+1) inside the ALU and are passed through unmodified.
- **Reset:** asynchronous assertion clears the FIFO, pointers, `count`, and all outputs, and sets state to IDLE. Queued or in-flight commands are discarded. Outputs return to reset values immediately, not at the next edge.

## Timing
- **Reset values:** `cmd_ready = 1`; `res_valid = 0`; `res_data = 0`; `res_code = 0`; `alu_code = 0`; `alu_a = 0`; `alu_b = 0`; `count = 0`.
- **Latency:** a command accepted at edge N into an empty, idle block is loaded to `alu_*` at edge N+1. It is captured at edge N+2, so `res_valid` is high in the cycle after edge N+2.
- **Back-to-back throughput:** one result per 2 cycles when `res_ready` is held high.
- **Handshake:** `res_valid` never deasserts without `res_ready`. `res_data`/`res_code` are stable while `res_valid && !res_ready`.
- **`count`:** updates at the push/pop edge and is visible the next cycle.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants `OP_AND`, `OP_OR`, `OP_SUB`, `OP_ADD`;
  - default `OPW`;
  - FSM state encoding IDLE/EXEC/WAIT.
- **Sub-module `alu_cmd_fifo`:** a parameterised synchronous FIFO with push, pop, head data, and count. It stores {code, a, b}.
- **Top level:** holds the FSM, the `alu_*` output registers, and the result registers.

## Test plan
- **Reset and single command:** reset, then push {ADD, 4'd9, 4'd8} with `res_ready = 1`.
  - `res_valid` rises 2 cycles after acceptance with `res_data = 5'd17`, `res_code = 11`.
  - `count` returns to 0.
- **Wrap and AND masking:** push SUB 3−5, then AND 4'hF & 4'hA, with an ALU model that leaves `c[4]` at 1 for AND.
  - Results are 5'h1E, then 5'h0A (bit 4 forced to 0).
- **Backpressure:** fill with 4 commands while `res_ready = 0`.
  - After the first pop, `count` peaks at 4 and `cmd_ready = 0`.
  - An extra `cmd_valid` is ignored.
  - `res_data` stays stable until `res_ready`, and results then emerge in order.
- **Simultaneous push/pop:** stream 8 commands with `cmd_valid` and `res_ready` held high.
  - All 8 results arrive in order, one every 2 cycles.
  - Pointers wrap, with no loss or duplication.
- **Reset mid-operation:** assert `rst_n = 0` asynchronously in EXEC with 3 commands queued.
  - All outputs go to reset values immediately.
  - After release, no stale result appears and `count = 0`.
